// File: rtl/dcache_pkg.sv
// Shared constants and state encoding for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int LINES      = 32;
    localparam int BLOCK_BITS = 256;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;

    localparam int IDX_W  = $clog2(LINES);
    localparam int OFS_W  = $clog2(BLOCK_BITS / 8);
    localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
    localparam int WORDS  = BLOCK_BITS / WORD_W;
    localparam int WSEL_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, bundled together.
// slave = the cache controller's view, master = the pipeline/memory side.
interface dcache_if;
    import dcache_pkg::*;

    logic [ADDR_W-1:0]     p1_addr_i;
    logic [WORD_W-1:0]     p1_data_i;
    logic                  p1_MemRead_i;
    logic                  p1_MemWrite_i;
    logic [WORD_W-1:0]     p1_data_o;
    logic                  p1_stall_o;

    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the cache. Reads are asynchronous by index;
// a refill writes a whole line (valid, clean), a store writes one word (dirty).
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [BLOCK_BITS-1:0] line_data,
    input  logic                  word_we,
    input  logic [WSEL_W-1:0]     word_sel,
    input  logic [WORD_W-1:0]     word_data,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_BITS-1:0] rd_line
);

    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [BLOCK_BITS-1:0] data_mem [LINES];

    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

    // Line status bits: cleared by reset, set valid/clean on refill, dirty on store.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (word_we) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= line_tag;
            data_mem[idx] <= line_data;
        end else if (word_we) begin
            data_mem[idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// A miss stalls the pipeline while the dirty victim is written back and the
// requested block is refilled; the held request then replays as a hit.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);

    state_t state, next_state;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      idx;
    logic [WSEL_W-1:0]     word_sel;
    logic [1:0]            unused_byte_ofs;
    logic                  req, is_write, hit;

    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_BITS-1:0] rd_line;
    logic [WORD_W-1:0]     rd_word;

    logic                  line_we, word_we;
    logic                  stall;
    logic [WORD_W-1:0]     rdata;
    logic                  mem_en, mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [BLOCK_BITS-1:0] mem_wdata;

    assign req_tag         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = bus.p1_addr_i[OFS_W +: IDX_W];
    assign word_sel        = bus.p1_addr_i[2 +: WSEL_W];
    assign unused_byte_ofs = bus.p1_addr_i[1:0];

    // A simultaneous read and write request is handled as a write.
    assign req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign is_write = bus.p1_MemWrite_i;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign rd_word  = rd_line[word_sel*WORD_W +: WORD_W];

    dcache_sram u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .line_we   (line_we & ~rst_i),
        .line_tag  (req_tag),
        .line_data (bus.mem_data_i),
        .word_we   (word_we & ~rst_i),
        .word_sel  (word_sel),
        .word_data (bus.p1_data_i),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line)
    );

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state, hit service, and memory request driven from the registered state.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        rdata      = '0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        line_we    = 1'b0;
        word_we    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (is_write) word_we = 1'b1;
                        else          rdata   = rd_word;
                    end else begin
                        stall      = 1'b1;
                        next_state = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {rd_tag, idx, {OFS_W{1'b0}}};
                mem_wdata = rd_line;
                if (bus.mem_ack_i) next_state = ST_REFILL;
            end
            ST_REFILL: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {req_tag, idx, {OFS_W{1'b0}}};
                if (bus.mem_ack_i) begin
                    line_we    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bus.p1_data_o    = rdata;
    assign bus.p1_stall_o   = stall;
    assign bus.mem_enable_o = mem_en;
    assign bus.mem_write_o  = mem_wr;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_data_o   = mem_wdata;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus queues expected CPU and
// memory responses, independent monitors pop and compare them.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    dcache_if bus();

    dcache_controller dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          stall;
        string       name;
    } cpu_exp_t;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [255:0]  data;
        string         name;
    } mem_exp_t;

    int checks = 0;
    int errors = 0;
    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    logic [255:0] mem_model [logic [31:0]];
    int ack_after = 4;
    bit hold_ack = 1'b0;
    bit stale_pulse = 1'b0;

    function automatic logic [255:0] pattern_block(logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'hC0DE_0000 ^ (a + 32'(w*4));
        return b;
    endfunction

    function automatic logic [255:0] blk0_init();
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'h1111_1111 * 32'(w+1);
        return b;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: ack after ack_after+1 enabled cycles, i.e. A cycles after enable rises.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            bus.mem_ack_i = 1'b0;
            if (stale_pulse) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = {8{32'hBAD0_BAD0}};
                stale_pulse    = 1'b0;
                cnt            = 0;
            end else if (bus.mem_enable_o && !hold_ack) begin
                cnt++;
                if (cnt == ack_after + 1) begin
                    cnt = 0;
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o)
                        mem_model[bus.mem_addr_o] = bus.mem_data_o;
                    else if (mem_model.exists(bus.mem_addr_o))
                        bus.mem_data_i = mem_model[bus.mem_addr_o];
                    else
                        bus.mem_data_i = pattern_block(bus.mem_addr_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // CPU-side monitor: on each completed access compare stall length and data.
    initial begin
        int stall_cnt;
        cpu_exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                stall_cnt = 0;
            end else if (bus.p1_MemRead_i || bus.p1_MemWrite_i) begin
                if (bus.p1_stall_o) begin
                    stall_cnt++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cpu_unexpected: access at %0h completed, none expected", bus.p1_addr_i);
                    end else begin
                        e = cpu_q.pop_front();
                        check({e.name, "_stall"}, 256'(stall_cnt), 256'(e.stall));
                        if (e.is_read) check({e.name, "_data"}, 256'(bus.p1_data_o), 256'(e.data));
                        else           check({e.name, "_data_zero"}, 256'(bus.p1_data_o), 256'(0));
                        check({e.name, "_mem_idle"}, 256'(bus.mem_enable_o), 256'(0));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory-side monitor: on each ack compare the transaction and its stability.
    initial begin
        bit in_txn;
        logic [31:0] ra;
        logic [255:0] rd;
        logic rw;
        mem_exp_t m;
        in_txn = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!bus.mem_enable_o) begin
                in_txn = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    ra = bus.mem_addr_o;
                    rd = bus.mem_data_o;
                    rw = bus.mem_write_o;
                end
                if (bus.mem_ack_i) begin
                    check("mem_addr_stable", 256'(bus.mem_addr_o), 256'(ra));
                    check("mem_data_stable", bus.mem_data_o, rd);
                    check("mem_write_stable", 256'(bus.mem_write_o), 256'(rw));
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: transaction at %0h, none expected", bus.mem_addr_o);
                    end else begin
                        m = mem_q.pop_front();
                        check({m.name, "_write"}, 256'(bus.mem_write_o), 256'(m.wr));
                        check({m.name, "_addr"}, 256'(bus.mem_addr_o), 256'(m.addr));
                        if (m.wr) check({m.name, "_block"}, bus.mem_data_o, m.data);
                    end
                    in_txn = 1'b0;
                end
            end
        end
    end

    task automatic access(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int exp_stall);
        int n;
        cpu_q.push_back('{is_read: rd && !wr, data: exp_data, stall: exp_stall, name: name});
        bus.p1_addr_i     = addr;
        bus.p1_data_i     = wdata;
        bus.p1_MemRead_i  = rd;
        bus.p1_MemWrite_i = wr;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (!bus.p1_stall_o) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: stall still %0d after %0d cycles, required 0", name, bus.p1_stall_o, n);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    task automatic push_mem(input string name, input logic wr, input logic [31:0] addr, input logic [255:0] data);
        mem_q.push_back('{wr: wr, addr: addr, data: data, name: name});
    endtask

    initial begin
        logic [255:0] wb0, wb1;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        mem_model[32'h0] = blk0_init();

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_stall", 256'(bus.p1_stall_o), 256'(0));
        check("rst_data", 256'(bus.p1_data_o), 256'(0));
        check("rst_mem_enable", 256'(bus.mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(bus.mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(bus.mem_addr_o), 256'(0));
        check("rst_mem_data", bus.mem_data_o, 256'(0));
        @(posedge clk_i);
        #1;

        // Cold read miss, clean: stall = 1 + 4 + 1.
        ack_after = 4;
        push_mem("refill_0", 1'b0, 32'h0000_0000, '0);
        access("rd_miss_0", 32'h0000_0000, 1, 0, 0, 32'h1111_1111, 6);
        access("rd_hit_4", 32'h0000_0004, 1, 0, 0, 32'h2222_2222, 0);
        access("wr_hit_8", 32'h0000_0008, 0, 1, 32'hDEAD_BEEF, 0, 0);
        access("rd_hit_8", 32'h0000_0008, 1, 0, 0, 32'hDEAD_BEEF, 0);
        access("rdwr_hit_c", 32'h0000_000C, 1, 1, 32'h0BAD_CAFE, 0, 0);
        access("rd_hit_c", 32'h0000_000C, 1, 0, 0, 32'h0BAD_CAFE, 0);

        // Conflict miss on dirty index 0: stall = 2*2 + 3.
        ack_after = 2;
        wb0 = blk0_init();
        wb0[2*32 +: 32] = 32'hDEAD_BEEF;
        wb0[3*32 +: 32] = 32'h0BAD_CAFE;
        push_mem("wb_0", 1'b1, 32'h0000_0000, wb0);
        push_mem("refill_400", 1'b0, 32'h0000_0400, '0);
        access("rd_miss_400", 32'h0000_0400, 1, 0, 0, 32'hC0DE_0400, 7);
        access("rd_hit_41c", 32'h0000_041C, 1, 0, 0, 32'hC0DE_041C, 0);

        // Write miss to a clean line: refill only, stall = 1 + 2 + 1.
        push_mem("refill_20", 1'b0, 32'h0000_0020, '0);
        access("wr_miss_24", 32'h0000_0024, 0, 1, 32'hCAFE_F00D, 0, 4);
        access("rd_hit_24", 32'h0000_0024, 1, 0, 0, 32'hCAFE_F00D, 0);
        access("rd_hit_20", 32'h0000_0020, 1, 0, 0, 32'hC0DE_0020, 0);
        access("rd_hit_3c", 32'h0000_003C, 1, 0, 0, 32'hC0DE_003C, 0);

        // Evict it: written-back block shows the merged store and refill words.
        wb1 = pattern_block(32'h0000_0020);
        wb1[1*32 +: 32] = 32'hCAFE_F00D;
        push_mem("wb_20", 1'b1, 32'h0000_0020, wb1);
        push_mem("refill_420", 1'b0, 32'h0000_0420, '0);
        access("rd_miss_420", 32'h0000_0420, 1, 0, 0, 32'hC0DE_0420, 7);

        // Block 0 comes back from memory with the written-back store.
        push_mem("refill_0b", 1'b0, 32'h0000_0000, '0);
        access("rd_miss_0b", 32'h0000_0000, 1, 0, 0, 32'h1111_1111, 4);
        access("rd_hit_8b", 32'h0000_0008, 1, 0, 0, 32'hDEAD_BEEF, 0);

        // Reset in the middle of a refill, then a stale ack.
        hold_ack = 1'b1;
        bus.p1_addr_i    = 32'h0000_0060;
        bus.p1_MemRead_i = 1'b1;
        @(negedge clk_i);
        check("abort_detect_stall", 256'(bus.p1_stall_o), 256'(1));
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("abort_enable", 256'(bus.mem_enable_o), 256'(1));
        check("abort_write", 256'(bus.mem_write_o), 256'(0));
        check("abort_addr", 256'(bus.mem_addr_o), 256'(32'h0000_0060));
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        bus.p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_enable_dropped", 256'(bus.mem_enable_o), 256'(0));
        check("abort_stall_dropped", 256'(bus.p1_stall_o), 256'(0));
        @(posedge clk_i);
        #1;
        stale_pulse = 1'b1;
        @(negedge clk_i);
        check("stale_ack_enable", 256'(bus.mem_enable_o), 256'(0));
        @(posedge clk_i);
        #1;
        hold_ack = 1'b0;
        @(negedge clk_i);
        check("stale_ack_idle", 256'(bus.mem_enable_o), 256'(0));
        @(posedge clk_i);
        #1;
        push_mem("refill_60", 1'b0, 32'h0000_0060, '0);
        access("rd_miss_60", 32'h0000_0060, 1, 0, 0, 32'hC0DE_0060, 4);

        repeat (3) @(posedge clk_i);
        check("cpu_q_drained", 256'(cpu_q.size()), 256'(0));
        check("mem_q_drained", 256'(mem_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
